// File: rtl/mmio_gpio_bank_if.sv
// Data-memory bus slice seen by the GPIO bank: word address, lane-placed write
// data with byte strobes, access qualifiers and the registered read return.
interface mmio_gpio_bank_if;
  logic [29:0] MADDR;
  logic [31:0] MDATAO;
  logic [3:0]  MWSTB;
  logic        WE;
  logic        RE;
  logic [31:0] RDATA;
  logic        RHIT;

  modport master (output MADDR, MDATAO, MWSTB, WE, RE, input RDATA, RHIT);
  modport slave  (input MADDR, MDATAO, MWSTB, WE, RE, output RDATA, RHIT);
endinterface

// File: rtl/mmio_gpio_bank.sv
// Memory-mapped GPIO/LED bank: NCH channels with set/clear/toggle aliases,
// synchronised inputs with W1C rising-edge interrupts. Optional PWM: MMIO_GPIO_PWM_EN.
module mmio_gpio_bank #(
  parameter logic [31:0] BASE  = 32'h0012_0000,
  parameter int          NCH   = 4,
  parameter int          WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  mmio_gpio_bank_if.slave      bus,
  input  logic [NCH*WIDTH-1:0] GPIO_I,
  output logic [NCH*WIDTH-1:0] GPIO_O,
  output logic                 IRQ
);

  typedef logic [NCH-1:0][WIDTH-1:0] chan_vec_t;

  localparam logic [2:0] REG_OUT  = 3'd0;
  localparam logic [2:0] REG_SET  = 3'd1;
  localparam logic [2:0] REG_CLR  = 3'd2;
  localparam logic [2:0] REG_TGL  = 3'd3;
  localparam logic [2:0] REG_IN   = 3'd4;
  localparam logic [2:0] REG_DUTY = 3'd5;
  localparam logic [9:0] WOFF_STAT = 10'h100;
  localparam logic [9:0] WOFF_EN   = 10'h101;

  chan_vec_t        out_r;
  chan_vec_t        out_nxt_s;
  chan_vec_t        sync1_r;
  chan_vec_t        sync2_r;
  chan_vec_t        prev_r;
  logic [NCH-1:0]   stat_r;
  logic [NCH-1:0]   stat_nxt_s;
  logic [NCH-1:0]   stat_clr_s;
  logic [NCH-1:0]   en_r;
  logic [NCH-1:0]   en_nxt_s;
  logic [NCH-1:0]   edge_s;
  logic [1:0]       arm_r;
  logic             armed_s;
  logic             irq_r;
  logic [31:0]      rdata_r;
  logic             rhit_r;
  logic [31:0]      rmux_s;

  logic             hit_s;
  logic [9:0]       woff_s;
  logic [6:0]       ch_s;
  logic [2:0]       reg_s;
  logic             ch_hit_s;
  logic             wr_s;
  logic             rd_s;
  logic [31:0]      bmask_s;
  logic [WIDTH-1:0] wkeep_s;
  logic [WIDTH-1:0] wbits_s;
  logic [NCH-1:0]   nkeep_s;
  logic [NCH-1:0]   nbits_s;
  logic [WIDTH-1:0] sel_out_s;
  logic [WIDTH-1:0] sel_in_s;

  assign hit_s    = (bus.MADDR[29:10] == BASE[31:12]);
  assign woff_s   = bus.MADDR[9:0];
  assign ch_s     = woff_s[9:3];
  assign reg_s    = woff_s[2:0];
  assign ch_hit_s = (ch_s < 7'(NCH));
  assign wr_s     = bus.WE & hit_s;
  assign rd_s     = bus.RE & hit_s;
  assign bmask_s  = {{8{bus.MWSTB[3]}}, {8{bus.MWSTB[2]}}, {8{bus.MWSTB[1]}}, {8{bus.MWSTB[0]}}};
  assign wkeep_s  = bmask_s[WIDTH-1:0];
  assign wbits_s  = bus.MDATAO[WIDTH-1:0] & wkeep_s;
  assign nkeep_s  = bmask_s[NCH-1:0];
  assign nbits_s  = bus.MDATAO[NCH-1:0] & nkeep_s;

  // Edges are ignored until the synchroniser holds post-reset samples, so an
  // input already high at reset release never looks like a rising edge.
  assign armed_s    = (arm_r == 2'd3);
  assign stat_nxt_s = (stat_r & ~stat_clr_s) | edge_s;

  // Bus write decode: channel aliases and global registers, strobe-masked
  always_comb begin
    out_nxt_s  = out_r;
    en_nxt_s   = en_r;
    stat_clr_s = '0;
    for (int c = 0; c < NCH; c++) begin
      if (wr_s && (ch_s == 7'(c))) begin
        case (reg_s)
          REG_OUT: out_nxt_s[c] = (out_r[c] & ~wkeep_s) | wbits_s;
          REG_SET: out_nxt_s[c] = out_r[c] | wbits_s;
          REG_CLR: out_nxt_s[c] = out_r[c] & ~wbits_s;
          REG_TGL: out_nxt_s[c] = out_r[c] ^ wbits_s;
          default: out_nxt_s[c] = out_r[c];
        endcase
      end else begin
        out_nxt_s[c] = out_r[c];
      end
    end
    if (wr_s && (woff_s == WOFF_STAT)) begin
      stat_clr_s = nbits_s;
    end else if (wr_s && (woff_s == WOFF_EN)) begin
      en_nxt_s = (en_r & ~nkeep_s) | nbits_s;
    end else begin
      stat_clr_s = '0;
      en_nxt_s   = en_r;
    end
  end

  // Per-channel rising-edge detect and AND-OR channel select for reads
  always_comb begin
    edge_s    = '0;
    sel_out_s = '0;
    sel_in_s  = '0;
    for (int c = 0; c < NCH; c++) begin
      edge_s[c] = armed_s & (|(sync2_r[c] & ~prev_r[c]));
      sel_out_s = sel_out_s | ((ch_s == 7'(c)) ? out_r[c] : '0);
      sel_in_s  = sel_in_s | ((ch_s == 7'(c)) ? sync2_r[c] : '0);
    end
  end

`ifdef MMIO_GPIO_PWM_EN
  logic [NCH-1:0][7:0] duty_r;
  logic [NCH-1:0][7:0] duty_nxt_s;
  logic [7:0]          sel_duty_s;
  logic [7:0]          pcnt_r;
  chan_vec_t           pwm_s;
  chan_vec_t           gpio_o_r;

  // Duty writes (lane 0 only), PWM gating and duty read select
  always_comb begin
    duty_nxt_s = duty_r;
    pwm_s      = '0;
    sel_duty_s = 8'd0;
    for (int c = 0; c < NCH; c++) begin
      if (wr_s && (ch_s == 7'(c)) && (reg_s == REG_DUTY) && bus.MWSTB[0]) begin
        duty_nxt_s[c] = bus.MDATAO[7:0];
      end else begin
        duty_nxt_s[c] = duty_r[c];
      end
      pwm_s[c]   = out_r[c] & {WIDTH{(duty_r[c] == 8'hFF) || (pcnt_r < duty_r[c])}};
      sel_duty_s = sel_duty_s | ((ch_s == 7'(c)) ? duty_r[c] : 8'd0);
    end
  end

  // PWM counter, duty registers and glitch-free registered outputs
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      duty_r   <= '1;
      pcnt_r   <= 8'd0;
      gpio_o_r <= '0;
    end else begin
      duty_r   <= duty_nxt_s;
      pcnt_r   <= pcnt_r + 8'd1;
      gpio_o_r <= pwm_s;
    end
  end

  assign GPIO_O = gpio_o_r;
`else
  assign GPIO_O = out_r;
`endif

  // Read mux; out-of-range channels and unused offsets read zero
  always_comb begin
    rmux_s = 32'd0;
    if (woff_s == WOFF_STAT) begin
      rmux_s = 32'(stat_r);
    end else if (woff_s == WOFF_EN) begin
      rmux_s = 32'(en_r);
    end else if (ch_hit_s) begin
      case (reg_s)
        REG_OUT, REG_SET, REG_CLR, REG_TGL: rmux_s = 32'(sel_out_s);
        REG_IN:   rmux_s = 32'(sel_in_s);
`ifdef MMIO_GPIO_PWM_EN
        REG_DUTY: rmux_s = 32'(sel_duty_s);
`else
        REG_DUTY: rmux_s = 32'd0;
`endif
        default:  rmux_s = 32'd0;
      endcase
    end else begin
      rmux_s = 32'd0;
    end
  end

  // Register state, synchroniser chain, interrupt and read return
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      out_r   <= '0;
      stat_r  <= '0;
      en_r    <= '0;
      sync1_r <= '0;
      sync2_r <= '0;
      prev_r  <= '0;
      arm_r   <= 2'd0;
      irq_r   <= 1'b0;
      rdata_r <= 32'd0;
      rhit_r  <= 1'b0;
    end else begin
      out_r   <= out_nxt_s;
      stat_r  <= stat_nxt_s;
      en_r    <= en_nxt_s;
      sync1_r <= GPIO_I;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      arm_r   <= armed_s ? arm_r : (arm_r + 2'd1);
      irq_r   <= |(stat_r & en_r);
      rdata_r <= rd_s ? rmux_s : 32'd0;
      rhit_r  <= rd_s;
    end
  end

  assign IRQ       = irq_r;
  assign bus.RDATA = rdata_r;
  assign bus.RHIT  = rhit_r;

endmodule
